// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty fetch unit.
package bitty_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] INSTR_RST = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/bitty_prog_mem.sv
// Program RAM: one synchronous write port, one synchronous read port, 1-cycle read latency.
module bitty_prog_mem
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  // Write-first: a read of the address being written returns the new word.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Fetch/issue sequencer for the bitty core: program RAM, pc, and the IDLE/FETCH/ISSUE/WAIT FSM.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [ADDR_W-1:0]  i_last_addr,
  input  logic               i_prog_we,
  input  logic [ADDR_W-1:0]  i_prog_addr,
  input  logic [INSTR_W-1:0] i_prog_data,
  input  logic               i_done,
  output logic               o_run,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_busy,
  output logic               o_halted
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_last;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_run;
  logic                r_busy;
  logic                r_halted;
  logic                r_stop_pend;

  logic                w_idle;
  logic                w_we;
  logic                w_start;
  logic                w_done_ok;
  logic                w_halt;
  logic                w_adv;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [INSTR_W-1:0]  w_rd_data;

  assign w_idle    = (r_state == IDLE);
  assign w_we      = w_idle & i_prog_we;
  assign w_start   = w_idle & i_start;
  assign w_done_ok = (r_state == WAIT) & i_done;
  assign w_halt    = w_done_ok & (r_stop_pend | i_stop | (r_pc == r_last));
  assign w_adv     = w_done_ok & ~w_halt;
  assign w_pc_inc  = r_pc + ADDR_W'(1);

  // The read is launched on the edge that enters FETCH, addressed by the pc
  // being loaded there, so the word is ready to issue at the end of FETCH.
  assign w_rd_en   = w_start | w_adv;
  assign w_rd_addr = w_start ? '0 : w_pc_inc;

  bitty_prog_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_last      <= '0;
      r_instr     <= INSTR_RST;
      r_run       <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      if (r_busy && i_stop) r_stop_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_pc        <= '0;
            r_last      <= i_last_addr;
            r_halted    <= 1'b0;
            r_stop_pend <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          r_instr <= w_rd_data;
          r_run   <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_run   <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_halt) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_halted    <= 1'b1;
            r_stop_pend <= 1'b0;
          end else if (w_adv) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_run         = r_run;
  assign o_instruction = r_instr;
  assign o_pc          = r_pc;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Scoreboard bench for bitty_fetch_unit with a delayed-done core model.
module tb_bitty_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_stop, i_prog_we;
  logic [7:0]  i_last_addr, i_prog_addr;
  logic [15:0] i_prog_data;
  logic        core_done, spur_done;
  logic        w_done;
  logic        o_run, o_busy, o_halted;
  logic [15:0] o_instruction;
  logic [7:0]  o_pc;

  exp_t        sb[$];
  int          run_cyc[$];
  logic [15:0] mirror [256];
  int          n_chk = 0, n_bad = 0;
  int          cyc = 0, start_cyc = 0;
  int          core_dly = 1, core_n = 0, stop_at = 0;

  assign w_done = core_done | spur_done;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  bitty_fetch_unit #(.ADDR_W(8), .DEPTH(256)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_last_addr   (i_last_addr),
    .i_prog_we     (i_prog_we),
    .i_prog_addr   (i_prog_addr),
    .i_prog_data   (i_prog_data),
    .i_done        (w_done),
    .o_run         (o_run),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_busy        (o_busy),
    .o_halted      (o_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue monitor: every run pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (i_reset && o_run) begin
      run_cyc.push_back(cyc);
      if (sb.size() == 0) chk("extra_run", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", 32'(o_instruction), 32'(e.instr));
        chk("pc", 32'(o_pc), 32'(e.pc));
      end
    end
  end

  // Core model: done core_dly cycles after each run; optional stop in the first WAIT cycle.
  initial begin
    core_done = 1'b0;
    i_stop    = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset && o_run) begin
        core_n++;
        for (int k = 0; k < core_dly; k++) begin
          @(posedge i_clk); #1;
          i_stop = (k == 0) && (core_n == stop_at);
        end
        core_done = 1'b1;
        @(posedge i_clk); #1;
        core_done = 1'b0;
        i_stop    = 1'b0;
      end
    end
  end

  task automatic load(input int a, input logic [15:0] d);
    i_prog_we = 1'b1; i_prog_addr = 8'(a); i_prog_data = d; mirror[a] = d;
    @(posedge i_clk); #1;
    i_prog_we = 1'b0;
  endtask

  task automatic wait_runs(input int n);
    int k = 0;
    while (run_cyc.size() < n && k < 500) begin
      @(posedge i_clk); #1; k++;
    end
    if (k >= 500) chk("run_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_prog(input int last, input int dly, input int stop_n, input int n_exp,
                          input bit poke, input bit wr_start, input logic [15:0] wr_data);
    int k = 0;
    if (wr_start) mirror[0] = wr_data;
    for (int i = 0; i < n_exp; i++) sb.push_back('{instr: mirror[i], pc: 8'(i)});
    core_dly = dly; stop_at = stop_n; core_n = 0;
    run_cyc.delete();
    i_last_addr = 8'(last);
    i_start = 1'b1;
    if (wr_start) begin
      i_prog_we = 1'b1; i_prog_addr = 8'h00; i_prog_data = wr_data;
    end
    start_cyc = cyc;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_prog_we = 1'b0;
    if (poke) begin
      i_prog_we = 1'b1; i_prog_addr = 8'h00; i_prog_data = 16'hFFFF;
      repeat (3) @(posedge i_clk);
      #1 i_prog_we = 1'b0;
    end
    while (o_busy && k < 3000) begin
      @(posedge i_clk); #1; k++;
    end
    if (k >= 3000) chk("busy_timeout", 32'd0, 32'd1);
    @(negedge i_clk);
    chk("end_busy", 32'(o_busy), 32'd0);
    chk("end_halted", 32'(o_halted), 32'd1);
    chk("end_pc", 32'(o_pc), 32'(n_exp - 1));
    chk("run_count", 32'(run_cyc.size()), 32'(n_exp));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_prog_we = 1'b0; spur_done = 1'b0;
    i_last_addr = 8'h00; i_prog_addr = 8'h00; i_prog_data = 16'h0000;
    #1;
    chk("rst_run", 32'(o_run), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_instr", 32'(o_instruction), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;

    load(0, 16'h1234); load(1, 16'h5678); load(2, 16'h9ABC);
    for (int a = 3; a <= 10; a++) load(a, 16'hA000 + 16'(a));

    // basic three-instruction program, slow core
    run_prog(2, 4, 0, 3, 1'b0, 1'b0, 16'h0);

    // fast core: latency, spacing, ignored start in WAIT and done in FETCH
    fork
      run_prog(2, 1, 0, 3, 1'b0, 1'b0, 16'h0);
      begin
        wait_runs(1);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; spur_done = 1'b1;
        @(posedge i_clk); #1;
        spur_done = 1'b0;
      end
    join
    if (run_cyc.size() == 3) begin
      // run shows up in the third cycle counting the start cycle itself
      chk("start_to_run", 32'(run_cyc[0] - start_cyc), 32'd2);
      chk("run_space0", 32'(run_cyc[1] - run_cyc[0]), 32'd3);
      chk("run_space1", 32'(run_cyc[2] - run_cyc[1]), 32'd3);
    end else chk("lat_runs", 32'(run_cyc.size()), 32'd3);

    // stop during the second instruction's WAIT
    run_prog(10, 4, 2, 2, 1'b0, 1'b0, 16'h0);
    repeat (8) @(posedge i_clk);
    #1 chk("no_run_after_stop", 32'(run_cyc.size()), 32'd2);

    // writes while busy are dropped; the restart sees the original word
    run_prog(0, 4, 0, 1, 1'b1, 1'b0, 16'h0);
    run_prog(0, 2, 0, 1, 1'b0, 1'b0, 16'h0);

    // start with a same-cycle write to address 0
    run_prog(0, 2, 0, 1, 1'b0, 1'b1, 16'h4321);

    // async reset in the middle of the second instruction's WAIT
    sb.push_back('{instr: mirror[0], pc: 8'd0});
    sb.push_back('{instr: mirror[1], pc: 8'd1});
    core_dly = 6; stop_at = 0; core_n = 0;
    run_cyc.delete();
    i_last_addr = 8'd2; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    wait_runs(2);
    chk("pre_rst_pc", 32'(o_pc), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("mid_rst_run", 32'(o_run), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_pc", 32'(o_pc), 32'd0);
    chk("mid_rst_instr", 32'(o_instruction), 32'd0);
    repeat (10) @(posedge i_clk);
    #1 i_reset = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 chk("post_rst_busy", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
